point_on_curve_check: RTL
=========================

// Module: point_on_curve_check
// PURPOSE
//  Sequential checker consuming the affine (x,y) result of the point scalar-multiply stage.
//  - Decides whether y^2 == x^3 + a*x + b (mod p), using a bit-serial modular multiplier.
//  - Sits directly downstream of the scalar multiplier and gates whether its result is used.
//  - The all-ones encoding {x,y} == {WIDTH{1'b1}} is the point at infinity and is reported as valid.
// PARAMETERS
//  WIDTH  256  operand width in bits; also the iteration count of each modular multiply
// PORTS
//  i_clk       in   1      clock; all logic on rising edge
//  i_rst       in   1      asynchronous, active-high reset
//  i_start     in   1      start pulse; sampled only in IDLE
//  i_a         in   WIDTH  curve coefficient a (caller guarantees a < p)
//  i_b         in   WIDTH  curve coefficient b (caller guarantees b < p)
//  i_p         in   WIDTH  field prime, odd, > 2
//  i_x         in   WIDTH  point x (from scalar-multiply o_result_x)
//  i_y         in   WIDTH  point y (from scalar-multiply o_result_y)
//  o_busy      out  1      high in every state except IDLE
//  o_finished  out  1      one-cycle pulse; o_on_curve is valid in the same cycle
//  o_on_curve  out  1      1 = point on curve or infinity; held until the next accepted start
// BEHAVIOUR
//  - Reset: o_busy=0, o_finished=0, o_on_curve=0, FSM->IDLE; sub-multiplier idle.
//  - Reset asserted mid-operation aborts immediately; no o_finished pulse is produced.
//  - Inputs i_a/i_b/i_p/i_x/i_y are latched on the accepting edge; later changes are ignored.
//  - i_start while busy is ignored (no queueing).
//  - o_on_curve is cleared on the accepting edge.
//  FSM:
//   IDLE  : i_start -> RANGE
//   RANGE : 1 cycle. If infinity -> DONE with on_curve=1.
//           Else if x>=p or y>=p -> DONE with on_curve=0.
//           Else -> MUL_YY.
//   MUL_YY : t_y = y*y mod p
//   MUL_XX : t = x*x mod p
//   MUL_XXX: t = t*x mod p
//   MUL_AX : u = a*x mod p
//   Each MUL state is WIDTH+1 cycles: 1 issue cycle plus WIDTH iterations.
//   SUM1 : s = (t+u) mod p
//   SUM2 : s = (s+b) mod p, then on_curve = (s == t_y)
//   DONE : o_finished=1 for 1 cycle -> IDLE
//  Latency (edge sampling i_start to edge raising o_finished):
//   - full path: exactly 4*WIDTH+8 cycles (1032 at WIDTH=256)
//   - early exit: exactly 2 cycles
//  Arithmetic:
//   - mod add: WIDTH+1-bit sum; subtract p once if sum >= p. Operands are always < p.
//   - mod mul: MSB-first interleaved. acc=0; per bit i from WIDTH-1 down to 0:
//       acc = 2*acc mod p;
//       if op_b[i] then acc = acc + op_a mod p.
//   - Intermediates are never wider than WIDTH+1 bits.
//  Boundaries:
//   - x=0 gives t=u=0 and must still run the full path.
//   - p = 2^WIDTH - small must not overflow the doubling step.
//   - a=0 must yield u=0.
// CONFIGURATION
//  POINT_CHECK_ERRCODE_EN defined: adds port o_err_code (out, 2 bits).
//   - Codes: 00 on curve, 01 infinity, 10 coordinate out of range, 11 equation mismatch.
//   - Valid with o_finished and held like o_on_curve; reset value 00.
//  Undefined: port and logic absent; o_on_curve behaviour identical.
// STRUCTURE
//  Shared package ecc_pkg:
//   - state enum
//   - err-code localparams ERR_OK / ERR_INF / ERR_RANGE / ERR_MISMATCH
//   - function mod_add(s,t,p)
//  Sub-module mod_mul_serial (i_clk, i_rst, i_start, i_a, i_b, i_p, o_result, o_done):
//   - o_done is a 1-cycle pulse exactly WIDTH cycles after i_start is sampled.
//   - It is reused by the checker for all four multiplies.
// TESTING
//  1 WIDTH=8, p=23, a=1, b=1, (x,y)=(3,10) -> o_on_curve=1 after 40 cycles; err 00.
//  2 Same curve, (3,11) -> o_on_curve=0 after 40 cycles; err 11.
//  3 WIDTH=8, (x,y)=(8'hFF,8'hFF) -> o_on_curve=1 after 2 cycles; err 01.
//  4 WIDTH=8, p=23, (x,y)=(23,5) -> o_on_curve=0 after 2 cycles; err 10.
//  5 WIDTH=256, secp256k1 (a=0, b=7), p=FFFF...FFFE_FFFFFC2F, generator G:
//    - x=79BE667E..16F81798, y=483ADA77..FB10D4B8 -> o_on_curve=1 after 1032 cycles.
//    - Same G with y xor 1 -> 0.
//  6 Start case 1, pulse i_start again mid-run (ignored), then assert i_rst at cycle 20:
//    - outputs return to reset values and no o_finished pulse occurs.
//    - A fresh case 1 then passes in 40 cycles.

Source files
------------

// File: rtl/ecc_pkg.sv
// +--------------------------------------------------------------------------+
// | ecc_pkg : shared types, result codes and modular add for the ECC checker |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ecc_pkg;

  // Widest operand supported; narrower users zero-extend into mod_add.
  localparam int MAX_W = 256;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RANGE   = 4'd1,
    S_MUL_YY  = 4'd2,
    S_MUL_XX  = 4'd3,
    S_MUL_XXX = 4'd4,
    S_MUL_AX  = 4'd5,
    S_SUM1    = 4'd6,
    S_SUM2    = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_INF      = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_MISMATCH = 2'b11;

  // (s + t) mod p for s, t < p; one extra bit holds the carry.
  function automatic logic [MAX_W-1:0] mod_add(input logic [MAX_W-1:0] s,
                                               input logic [MAX_W-1:0] t,
                                               input logic [MAX_W-1:0] p);
    logic [MAX_W:0] sum;
    sum = {1'b0, s} + {1'b0, t};
    if (sum >= {1'b0, p}) begin
      sum = sum - {1'b0, p};
    end
    return sum[MAX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_mul_serial.sv
// +--------------------------------------------------------------------------+
// | mod_mul_serial : MSB-first interleaved modular multiplier, 1 bit/cycle   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mod_mul_serial
  import ecc_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0] w_step;

  // Doubling reuses the modular adder, so 2*acc never exceeds WIDTH+1 bits.
  assign w_dbl  = WIDTH'(mod_add(MAX_W'(r_acc), MAX_W'(r_acc), MAX_W'(r_p)));
  assign w_step = r_b[WIDTH-1] ? WIDTH'(mod_add(MAX_W'(w_dbl), MAX_W'(r_a), MAX_W'(r_p)))
                               : w_dbl;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_a    <= i_a;
        r_b    <= i_b;
        r_p    <= i_p;
        r_acc  <= '0;
        r_cnt  <= CW'(WIDTH);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_step;
        r_b   <= {r_b[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_result = r_acc;
  assign o_done   = r_done;

endmodule

`default_nettype wire

// File: rtl/point_on_curve_check.sv
// +--------------------------------------------------------------------------+
// | point_on_curve_check : sequential y^2 == x^3+ax+b (mod p) checker        |
// | Optional o_err_code port under POINT_CHECK_ERRCODE_EN.  Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module point_on_curve_check
  import ecc_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_busy,
  output logic             o_finished,
`ifdef POINT_CHECK_ERRCODE_EN
  output logic [1:0]       o_err_code,
`endif
  output logic             o_on_curve
);

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a, r_b, r_p, r_x, r_y;
  logic [WIDTH-1:0] r_ty, r_t, r_u, r_s;
  logic             r_on_curve;
  logic             r_finished;
`ifdef POINT_CHECK_ERRCODE_EN
  logic [1:0]       r_err;
`endif

  logic             w_busy;
  logic             w_mul_start;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_mul_done;
  logic             w_inf;
  logic             w_oor;
  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_s2;

  assign w_inf = (r_x == {WIDTH{1'b1}}) && (r_y == {WIDTH{1'b1}});
  assign w_oor = (r_x >= r_p) || (r_y >= r_p);
  assign w_s1  = WIDTH'(mod_add(MAX_W'(r_t), MAX_W'(r_u), MAX_W'(r_p)));
  assign w_s2  = WIDTH'(mod_add(MAX_W'(r_s), MAX_W'(r_b), MAX_W'(r_p)));

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_mul_start),
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .i_p      (r_p),
    .o_result (w_mul_res),
    .o_done   (w_mul_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_RANGE;
      S_RANGE:   w_next = (w_inf || w_oor) ? S_DONE : S_MUL_YY;
      S_MUL_YY:  if (w_mul_done) w_next = S_MUL_XX;
      S_MUL_XX:  if (w_mul_done) w_next = S_MUL_XXX;
      S_MUL_XXX: if (w_mul_done) w_next = S_MUL_AX;
      S_MUL_AX:  if (w_mul_done) w_next = S_SUM1;
      S_SUM1:    w_next = S_SUM2;
      S_SUM2:    w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // The multiplier is launched on the edge that enters each MUL state, so
  // that edge is the issue cycle; operands are chosen by the state entered.
  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_mul_start = 1'b0;
    w_op_a      = '0;
    w_op_b      = '0;
    case (w_next)
      S_MUL_YY:  begin w_op_a = r_y;       w_op_b = r_y; end
      S_MUL_XX:  begin w_op_a = r_x;       w_op_b = r_x; end
      S_MUL_XXX: begin w_op_a = w_mul_res; w_op_b = r_x; end
      S_MUL_AX:  begin w_op_a = r_a;       w_op_b = r_x; end
      default:   begin w_op_a = '0;        w_op_b = '0;  end
    endcase
    if ((w_next != r_state) &&
        ((w_next == S_MUL_YY) || (w_next == S_MUL_XX) ||
         (w_next == S_MUL_XXX) || (w_next == S_MUL_AX))) begin
      w_mul_start = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_p        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_ty       <= '0;
      r_t        <= '0;
      r_u        <= '0;
      r_s        <= '0;
      r_on_curve <= 1'b0;
      r_finished <= 1'b0;
`ifdef POINT_CHECK_ERRCODE_EN
      r_err      <= ERR_OK;
`endif
    end else begin
      r_finished <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: if (i_start) begin
          r_a        <= i_a;
          r_b        <= i_b;
          r_p        <= i_p;
          r_x        <= i_x;
          r_y        <= i_y;
          r_on_curve <= 1'b0;
`ifdef POINT_CHECK_ERRCODE_EN
          r_err      <= ERR_OK;
`endif
        end
        S_RANGE: begin
          if (w_inf) begin
            r_on_curve <= 1'b1;
`ifdef POINT_CHECK_ERRCODE_EN
            r_err      <= ERR_INF;
`endif
          end else if (w_oor) begin
            r_on_curve <= 1'b0;
`ifdef POINT_CHECK_ERRCODE_EN
            r_err      <= ERR_RANGE;
`endif
          end
        end
        S_MUL_YY:  if (w_mul_done) r_ty <= w_mul_res;
        S_MUL_XXX: if (w_mul_done) r_t  <= w_mul_res;
        S_MUL_AX:  if (w_mul_done) r_u  <= w_mul_res;
        S_SUM1:    r_s <= w_s1;
        S_SUM2: begin
          r_on_curve <= (w_s2 == r_ty);
`ifdef POINT_CHECK_ERRCODE_EN
          r_err      <= (w_s2 == r_ty) ? ERR_OK : ERR_MISMATCH;
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = w_busy;
  assign o_finished = r_finished;
  assign o_on_curve = r_on_curve;
`ifdef POINT_CHECK_ERRCODE_EN
  assign o_err_code = r_err;
`endif

endmodule

`default_nettype wire
